// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// latched request record and access-legality helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_RMW_RD = 3'd2;
   localparam logic [2:0] S_WRITE  = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

   // funct3[1:0] gives the access size for both signed and unsigned loads
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
   endfunction

   function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
      if (we)
         return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
      return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: extends a loaded byte/half-word and merges store data into a word.
// Latency: purely combinational.
// Backpressure: none; consumed only by the owning FSM.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] raw,
   input  logic [31:0] wdata,
   output logic [31:0] ld_val,
   output logic [31:0] st_word
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = raw[{addr_lo, 3'b000} +: 8];
      lane_h = addr_lo[1] ? raw[31:16] : raw[15:0];

      ld_val = raw;
      case (funct3)
         F3_B:    ld_val = {{24{lane_b[7]}}, lane_b};
         F3_BU:   ld_val = {24'h0, lane_b};
         F3_H:    ld_val = {{16{lane_h[15]}}, lane_h};
         F3_HU:   ld_val = {16'h0, lane_h};
         default: ld_val = raw;
      endcase

      st_word = raw;
      case (funct3[1:0])
         2'b00: st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
         2'b01: begin
            if (addr_lo[1])
               st_word[31:16] = wdata[15:0];
            else
               st_word[15:0] = wdata[15:0];
         end
         default: st_word = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word RAM; sub-word stores done by read-modify-write.
// Latency from accept: fault 1, load/SW 2, SB/SH 3 cycles to resp_valid.
// Backpressure: one request in flight; req_ready low until the response is taken.
module lsu_rmw
   import lsu_pkg::*;
#(
   parameter bit MEM_A_WORD = 1'b1
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_d,
   input  logic [31:0] mem_spo
);

   logic [2:0]  state_q;
   lsu_req_t    req_q;
   logic [31:0] mbuf_q;
   logic [31:0] rdata_q;
   logic        fault_q;
   logic [31:0] ld_val;
   logic [31:0] st_word;
   logic        bad_req;

   lsu_align u_align (
      .funct3  (req_q.funct3),
      .addr_lo (req_q.addr[1:0]),
      .raw     (mem_spo),
      .wdata   (req_q.wdata),
      .ld_val  (ld_val),
      .st_word (st_word)
   );

   assign bad_req    = illegal_f3(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_fault = fault_q;
   // Write strobe comes from the state register alone, so reset kills it at once
   assign mem_we     = (state_q == S_WRITE);
   assign mem_d      = mbuf_q;
   assign mem_a      = MEM_A_WORD ? {2'b00, req_q.addr[31:2]} : {req_q.addr[31:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         req_q   <= '0;
         mbuf_q  <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  req_q.we     <= req_we;
                  req_q.funct3 <= req_funct3;
                  req_q.addr   <= req_addr;
                  req_q.wdata  <= req_wdata;
                  rdata_q      <= '0;
                  fault_q      <= bad_req;
                  if (bad_req)
                     state_q <= S_RESP;
                  else if (!req_we)
                     state_q <= S_LOAD;
                  else if (req_funct3 == F3_W) begin
                     mbuf_q  <= req_wdata;
                     state_q <= S_WRITE;
                  end else
                     state_q <= S_RMW_RD;
               end
            end
            S_LOAD: begin
               rdata_q <= ld_val;
               state_q <= S_RESP;
            end
            S_RMW_RD: begin
               mbuf_q  <= st_word;
               state_q <= S_WRITE;
            end
            S_WRITE: state_q <= S_RESP;
            S_RESP: begin
               if (resp_ready)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: directed vector table, stall and mid-RMW reset sequences,
// then random requests scored against a byte-lane memory model.
module tb_lsu_rmw;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_d;
   logic [31:0] mem_spo;

   lsu_rmw #(.MEM_A_WORD(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_d      (mem_d),
      .mem_spo    (mem_spo)
   );

   always #5 clk = ~clk;

   // Word RAM seen by the DUT, indexed by the low bits of the word index
   logic [31:0] ram [256];
   logic        ram_clr = 1'b1;
   assign mem_spo = ram[mem_a[7:0]];
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      end else if (mem_we) begin
         ram[mem_a[7:0]] <= mem_d;
      end
   end

   int          we_cnt = 0;
   logic [31:0] last_d = 32'h0;
   logic [31:0] last_a = 32'h0;
   always @(posedge clk) begin
      if (mem_we) begin
         we_cnt <= we_cnt + 1;
         last_d <= mem_d;
         last_a <= mem_a;
      end
   end

   logic [31:0] mmem [256];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: legality by size/alignment, lanes by shifting and masking bytes
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic flt, output int lat);
      logic [31:0] w, mask;
      int size, sh;
      logic legal;
      rd = 32'h0;
      flt = 1'b0;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
      if (!legal || (int'(addr[1:0]) % size) != 0) begin
         flt = 1'b1;
         lat = 1;
         return;
      end
      w  = mmem[addr[9:2]];
      sh = 8 * int'(addr[1:0]);
      if (!we) begin
         rd = w >> sh;
         if (size == 1) begin
            rd = rd & 32'hFF;
            if (f3 == 3'd0 && rd[7]) rd = rd | 32'hFFFF_FF00;
         end else if (size == 2) begin
            rd = rd & 32'hFFFF;
            if (f3 == 3'd1 && rd[15]) rd = rd | 32'hFFFF_0000;
         end
         lat = 2;
      end else begin
         if (size == 4) mask = 32'hFFFF_FFFF;
         else mask = ((32'h1 << (8 * size)) - 32'h1) << sh;
         mmem[addr[9:2]] = (w & ~mask) | ((wdata << sh) & mask);
         lat = (size == 4) ? 2 : 3;
      end
   endtask

   // Issues one request at a negedge, returns at a negedge after the handshake
   task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                         input logic [31:0] exp_rd, input logic exp_flt, input int exp_lat);
      int c0, lat;
      logic [31:0] rd_seen;
      c0 = we_cnt;
      resp_ready = (stall == 0);
      chk({name, ".req_ready"}, {31'h0, req_ready}, 32'h1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = n;
            break;
         end
      end
      if (lat == 0) begin
         checks++;
         errors++;
         $display("FAIL %s.timeout actual=no_resp required=resp_valid", name);
         resp_ready = 1'b1;
         return;
      end
      chk({name, ".lat"}, lat, exp_lat);
      chk({name, ".rdata"}, resp_rdata, exp_rd);
      chk({name, ".fault"}, {31'h0, resp_fault}, {31'h0, exp_flt});
      chk({name, ".we_pulses"}, we_cnt - c0, (we && !exp_flt) ? 1 : 0);
      if (we && !exp_flt) begin
         chk({name, ".mem_d"}, last_d, mmem[addr[9:2]]);
         chk({name, ".mem_a"}, last_a, {2'b00, addr[31:2]});
      end
      rd_seen = resp_rdata;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({name, ".stall_valid"}, {31'h0, resp_valid}, 32'h1);
         chk({name, ".stall_rdata"}, resp_rdata, rd_seen);
         chk({name, ".stall_ready"}, {31'h0, req_ready}, 32'h0);
         chk({name, ".stall_we"}, we_cnt - c0, (we && !exp_flt) ? 1 : 0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({name, ".post_valid"}, {31'h0, resp_valid}, 32'h0);
      chk({name, ".post_ready"}, {31'h0, req_ready}, 32'h1);
      @(negedge clk);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic        flt;
      int          lat;
   } vec_t;

   initial begin
      vec_t tv[15];
      logic [31:0] m_rd;
      logic m_flt;
      int m_lat, c0;
      logic r_we;
      logic [2:0] r_f3;
      logic [31:0] r_addr, r_wdata;

      tv[0]  = '{1'b1, 3'd2, 32'h0000_0010, 32'h8070_6050, 32'h0, 1'b0, 2};
      tv[1]  = '{1'b0, 3'd0, 32'h0000_0013, 32'h0, 32'hFFFF_FF80, 1'b0, 2};
      tv[2]  = '{1'b0, 3'd5, 32'h0000_0012, 32'h0, 32'h0000_8070, 1'b0, 2};
      tv[3]  = '{1'b0, 3'd1, 32'h0000_0012, 32'h0, 32'hFFFF_8070, 1'b0, 2};
      tv[4]  = '{1'b0, 3'd4, 32'h0000_0010, 32'h0, 32'h0000_0050, 1'b0, 2};
      tv[5]  = '{1'b1, 3'd0, 32'h0000_0011, 32'h0000_00AB, 32'h0, 1'b0, 3};
      tv[6]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0, 32'h8070_AB50, 1'b0, 2};
      tv[7]  = '{1'b1, 3'd2, 32'h0000_000E, 32'h1234_5678, 32'h0, 1'b1, 1};
      tv[8]  = '{1'b0, 3'd3, 32'h0000_0010, 32'h0, 32'h0, 1'b1, 1};
      tv[9]  = '{1'b0, 3'd1, 32'h0000_0013, 32'h0, 32'h0, 1'b1, 1};
      tv[10] = '{1'b1, 3'd2, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 1'b0, 2};
      tv[11] = '{1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0, 32'h1234_5678, 1'b0, 2};
      tv[12] = '{1'b1, 3'd1, 32'h0000_0022, 32'h0000_BEEF, 32'h0, 1'b0, 3};
      tv[13] = '{1'b0, 3'd2, 32'h0000_0020, 32'h0, 32'hBEEF_0000, 1'b0, 2};
      tv[14] = '{1'b1, 3'd4, 32'h0000_0020, 32'h5555_5555, 32'h0, 1'b1, 1};

      for (int i = 0; i < 256; i++) mmem[i] = 32'h0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      ram_clr = 1'b0;
      chk("rst.req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst.resp_rdata", resp_rdata, 32'h0);
      chk("rst.resp_fault", {31'h0, resp_fault}, 32'h0);
      chk("rst.mem_we", {31'h0, mem_we}, 32'h0);
      chk("rst.mem_a", mem_a, 32'h0);
      chk("rst.mem_d", mem_d, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 15; i++) begin
         model(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, m_rd, m_flt, m_lat);
         do_req($sformatf("vec%0d", i), tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, 0,
                tv[i].rd, tv[i].flt, tv[i].lat);
      end

      // Response held off for five cycles on a word load
      model(1'b0, 3'd2, 32'h10, 32'h0, m_rd, m_flt, m_lat);
      do_req("stall_lw", 1'b0, 3'd2, 32'h10, 32'h0, 5, 32'h8070_AB50, 1'b0, 2);

      // Reset pulled during the read phase of a half-word RMW
      c0 = we_cnt;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd1;
      req_addr   = 32'h20;
      req_wdata  = 32'h0000_1111;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("rmwrst.mem_a_before", mem_a, 32'h8);
      chk("rmwrst.ready_before", {31'h0, req_ready}, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("rmwrst.req_ready", {31'h0, req_ready}, 32'h1);
      chk("rmwrst.resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rmwrst.mem_we", {31'h0, mem_we}, 32'h0);
      chk("rmwrst.mem_a", mem_a, 32'h0);
      chk("rmwrst.mem_d", mem_d, 32'h0);
      chk("rmwrst.rdata", resp_rdata, 32'h0);
      chk("rmwrst.fault", {31'h0, resp_fault}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rmwrst.no_write", we_cnt - c0, 0);
      @(negedge clk);
      model(1'b0, 3'd2, 32'h20, 32'h0, m_rd, m_flt, m_lat);
      do_req("rmwrst.readback", 1'b0, 3'd2, 32'h20, 32'h0, 0, m_rd, m_flt, m_lat);

      for (int k = 0; k < 150; k++) begin
         r_we    = 1'($urandom_range(0, 1));
         r_f3    = 3'($urandom_range(0, 7));
         r_addr  = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) r_addr = r_addr | 32'hFFFF_FF00;
         r_wdata = $urandom;
         model(r_we, r_f3, r_addr, r_wdata, m_rd, m_flt, m_lat);
         do_req($sformatf("rnd%0d", k), r_we, r_f3, r_addr, r_wdata,
                int'($urandom_range(0, 2)), m_rd, m_flt, m_lat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
